prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_if.sv | 30 +++
 rtl/prog_loader.sv | 123 ++++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// Host byte stream and program-memory write port of the program loader.
// The loader connects through the slave modport; the host/memory side uses master.
interface prog_loader_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_data
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: streams DEPTH bytes from a host into program memory while holding the CPU.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte before release.
module prog_loader #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    prog_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         done,
    output logic         err
);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
`ifdef PROG_LOADER_CHECKSUM_EN
        StCheck,
`endif
        StRun,
        StError
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_data_q, mem_data_d;
    logic              in_ready;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

`ifdef PROG_LOADER_CHECKSUM_EN
    assign in_ready = (state_q == StLoad) || (state_q == StCheck);
`else
    assign in_ready = (state_q == StLoad);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        unique case (state_q)
            StIdle, StRun, StError: begin
                if (start) begin
                    state_d = StLoad;
                    cnt_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            StLoad: begin
                if (bus.in_valid) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = cnt_q;
                    mem_data_d = bus.in_data;
                    cnt_d      = cnt_q + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d      = sum_q + bus.in_data;
                    if (cnt_q == LastAddr) state_d = StCheck;
`else
                    if (cnt_q == LastAddr) state_d = StRun;
`endif
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            // The checksum byte is consumed here but never written to memory.
            StCheck: begin
                if (bus.in_valid) begin
                    state_d = (bus.in_data == sum_q) ? StRun : StError;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;

    // RUN is entered while the final strobe is still on the bus; keep the CPU held for it.
    assign cpu_hold = (state_q != StRun) || mem_we_q;
    assign done     = (state_q == StRun) && !mem_we_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign err      = (state_q == StError);
`else
    assign err      = 1'b0;
`endif
endmodule
